// File: rtl/aes_pkg.sv
// Shared types and constants for the INV_AES job scheduler.
// Byte i of every 128-bit bus sits at bits [8i+7:8i].
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  // FIPS-197 AES-128 vector, byte 0 in the low bits.
  localparam logic [BLOCK_W-1:0] FIPS_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [KEY_W-1:0]   FIPS_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [BLOCK_W-1:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;

endpackage

// File: rtl/aes_dec_scheduler_if.sv
// Host-side request/response bundle of the INV_AES scheduler.
// master = host requesters, slave = scheduler.
interface aes_dec_scheduler_if
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*BLOCK_W-1:0] req_data;
  logic [NUM_REQ*KEY_W-1:0]   req_key;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [BLOCK_W-1:0]         resp_data;
  logic [ID_W-1:0]            resp_id;
  logic                       resp_err;

  modport master (
    output req_valid, req_data, req_key, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_data, req_key, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: lowest requester above last_grant wins,
// otherwise wrap to the lowest requester overall.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] id_sel [ID_W];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask
    assign hi_mask[g] = (ID_W'(g) > last_grant);
  end

  assign req_hi  = req & hi_mask;
  assign pick    = (|req_hi) ? req_hi : req;
  // Isolate the lowest set bit of the chosen vector.
  assign gnt     = pick & (~pick + NUM_REQ'(1));
  assign gnt_any = |req;

  for (genvar b = 0; b < ID_W; b++) begin : g_enc_bit
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_enc_req
      assign id_sel[b][g] = gnt[g] && (((g >> b) & 1) != 0);
    end
    assign gnt_id[b] = |id_sel[b];
  end
endmodule

// File: rtl/aes_dec_scheduler.sv
// Round-robin scheduler sharing one INV_AES core among NUM_REQ requesters.
// Optional core watchdog: define AES_SCHED_TIMEOUT_EN.
module aes_dec_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  aes_dec_scheduler_if.slave bus,
  output logic               busy,
  output logic               core_read_en,
  output logic [BLOCK_W-1:0] core_data,
  output logic [KEY_W-1:0]   core_key,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_out_data
);
  localparam int ID_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    resp_id_q;
  logic [BLOCK_W-1:0] resp_data_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               grant;
  logic               tmo_hit;
  logic [BLOCK_W-1:0] data_arr [NUM_REQ];
  logic [KEY_W-1:0]   key_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.req_data[g*BLOCK_W +: BLOCK_W];
    assign key_arr[g]  = bus.req_key[g*KEY_W +: KEY_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_any    (gnt_any)
  );

  assign grant = (state_q == IDLE) && gnt_any;

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;

  // Counter is zero on the first RUN cycle; the limit-th RUN cycle aborts.
  assign tmo_hit = (state_q == RUN) && !core_done &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == RUN) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      else                tmo_cnt_q <= '0;
      if ((state_q == RUN) && (core_done || tmo_hit)) err_q <= tmo_hit;
    end
  end

  assign bus.resp_err = err_q;
`else
  assign tmo_hit      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: if (gnt_any) begin
        bus.req_ready = gnt;
        state_d       = RUN;
      end
      RUN:  if (core_done || tmo_hit) state_d = RESP;
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      core_data    <= '0;
      core_key     <= '0;
    end else begin
      if (grant) begin
        core_data    <= data_arr[gnt_id];
        core_key     <= key_arr[gnt_id];
        resp_id_q    <= gnt_id;
        last_grant_q <= gnt_id;
      end
      if ((state_q == RUN) && core_done) resp_data_q <= core_out_data;
      else if (tmo_hit)                  resp_data_q <= '0;
    end
  end

  assign busy           = (state_q != IDLE);
  assign core_read_en   = (state_q == RUN);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
endmodule
